// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: shifts a latched pattern out MSB-first,
// with optional repeats separated by idle gap cycles.
module serial_pattern_tx #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 4,
  parameter int GAP   = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic [CNT_W-1:0] repeats,
  output logic             out,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [LEN_W-1:0] MAXLEN = LEN_W'(WIDTH);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_GAP,
    ST_DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] pat_q;
  logic [WIDTH-1:0] sh;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] idx;
  logic [CNT_W-1:0] left;
  logic [GW-1:0]    gcnt;

  logic             legal;
  logic             last_bit;
  logic [WIDTH-1:0] aligned;

  assign legal    = (len != '0) && (len <= MAXLEN);
  assign last_bit = (idx == len_q - LEN_W'(1));
  // Left-align so the first bit to send always sits in the MSB
  assign aligned  = pattern << (MAXLEN - len);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= ST_IDLE;
      pat_q <= '0;
      sh    <= '0;
      len_q <= '0;
      idx   <= '0;
      left  <= '0;
      gcnt  <= '0;
      out   <= 1'b0;
      valid <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          out   <= 1'b0;
          valid <= 1'b0;
          busy  <= 1'b0;
          if (start) begin
            if (legal) begin
              pat_q <= aligned;
              sh    <= aligned << 1;
              out   <= aligned[WIDTH-1];
              valid <= 1'b1;
              busy  <= 1'b1;
              len_q <= len;
              left  <= repeats;
              idx   <= '0;
              state <= ST_SHIFT;
            end else begin
              err <= 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          if (!last_bit) begin
            idx <= idx + LEN_W'(1);
            out <= sh[WIDTH-1];
            sh  <= sh << 1;
          end else if (left != '0) begin
            left <= left - CNT_W'(1);
            idx  <= '0;
            if (GAP > 0) begin
              state <= ST_GAP;
              gcnt  <= GAP_LAST;
              out   <= 1'b0;
              valid <= 1'b0;
            end else begin
              out <= pat_q[WIDTH-1];
              sh  <= pat_q << 1;
            end
          end else begin
            state <= ST_DONE;
            out   <= 1'b0;
            valid <= 1'b0;
            done  <= 1'b1;
          end
        end
        ST_GAP: begin
          if (gcnt == '0) begin
            state <= ST_SHIFT;
            out   <= pat_q[WIDTH-1];
            sh    <= pat_q << 1;
            valid <= 1'b1;
          end else begin
            gcnt <= gcnt - GW'(1);
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
